box_overlay: RTL and testbench
==============================

# box_overlay

Draws a detection bounding box onto the video stream. This block consumes the frame-level box result (`en`, top/down/left/right) produced by the upstream target-judgement stage and paints a coloured rectangle border onto the pixel stream that feeds display or encoding. The box is latched once per frame so the drawn geometry is stable for the whole frame. A hold state machine keeps the last valid box visible for a few frames after detection drops out, which suppresses flicker.

## Interface
- `IMG_HDISP`, 12'd1280, active pixels per line
- `IMG_VDISP`, 12'd720, active lines per frame
- `THICK`, 4'd2, border thickness in pixels (1..15)
- `HOLD_FRAMES`, 4'd3, frames to keep drawing after `in_en` drops (0 = no hold)
- `BOX_COLOR`, 24'hFF0000, border pixel value
- `clk`  in  1  pixel clock (same as camera pipeline)
- `rst_n`  in  1  asynchronous, active-low reset
- `per_frame_vsync`  in  1  input frame valid
- `per_frame_href`  in  1  input line valid
- `per_frame_clken`  in  1  input pixel enable
- `per_img_Bit`  in  24  input pixel
- `in_en`  in  1  box valid from detector
- `in_top`, `in_down`, `in_left`, `in_right`  in  12 each  box edges (inclusive)
- `post_frame_vsync`, `post_frame_href`, `post_frame_clken`  out  1 each  delayed syncs
- `post_img_Bit`  out  24  output pixel
- `box_active`  out  1  a box is being drawn this frame

## Operation
- `vsync_pos_flag` = `per_frame_vsync & ~vsync_r`. `cap_flag` is `vsync_pos_flag` delayed by one cycle, because the detector updates its outputs on the `vsync_pos_flag` edge.
- x/y counters:
  - cleared on `vsync_pos_flag`.
  - On `per_frame_clken`, x increments; at `IMG_HDISP-1`, x wraps to 0 and y increments.
- FSM states: IDLE=0, SHOW=1, HOLD=2. It is evaluated only on `cap_flag`.
  - IDLE: if `in_en`, latch the box, set hold_cnt=0, go to SHOW.
  - SHOW: if `in_en`, re-latch the box. Otherwise, if `HOLD_FRAMES`==0 go to IDLE; else go to HOLD with hold_cnt=1, keeping the old box.
  - HOLD: if `in_en`, latch the box and go to SHOW. Else if hold_cnt==`HOLD_FRAMES`, go to IDLE. Else hold_cnt+1.
- Validity of the latched box:
  - A box is drawable only if `top<=down`, `left<=right`, and `right<IMG_HDISP`, `down<IMG_VDISP`.
  - A non-drawable box is latched as-is but suppresses drawing. It does not change FSM behaviour.
- `box_active` = (state SHOW or HOLD) and the box is drawable. It is registered on `cap_flag` and held for the frame.
- A pixel is a border pixel when all of the following hold:
  - `box_active`;
  - x in [left, right] and y in [top, down];
  - x<left+THICK, or x>right-THICK, or y<top+THICK, or y>down-THICK.
  - Compare in 13 bits so that `+THICK` never wraps.
- Border pixels output `BOX_COLOR`. All other pixels pass through unchanged. Blanking (`per_frame_clken`=0) pixels always pass through.
- Width rule: if the box is narrower than 2*`THICK`, the whole box is filled. No special case is needed.

## Timing
- Latency is 1 clock for all outputs: syncs, clken and pixel are registered together.
- Reset values:
  - all `post_*` = 0, `box_active` = 0;
  - state IDLE, hold_cnt 0, latched box all 0.
- Box inputs are sampled only on `cap_flag`. Changes at any other time have no effect until the next frame.
- `vsync_pos_flag` is asserted mid-frame when vsync glitches low and then high. Counters clear, and the FSM steps once on the following `cap_flag`.
- Async reset mid-frame: outputs drop to 0 immediately. Drawing resumes only after the next vsync rise with `in_en`.

## Configuration
- `BOX_CROSSHAIR_EN` defined: additionally paints the crosshair lines x==cx or y==cy inside the box in `BOX_COLOR`.
  - cx = `left[11:1]+right[11:1]`, cy = `top[11:1]+down[11:1]`, both registered on `cap_flag`.
- Undefined: border only. The cx/cy registers are absent.

## Test plan
- Reset, then a 1280x720 frame with `in_en`=0 → output equals input pixel-for-pixel with 1-cycle delay, and `box_active`=0.
- `in_en`=1, box (100,140,200,260) for top/down/left/right, `THICK`=2 → pixels at (200,100), (201,101), (260,140) and (230,139) are `BOX_COLOR`; (202,102) and (230,120) pass through.
- `in_en` drops after frame 1, `HOLD_FRAMES`=3 → box drawn in frames 2–4, absent in frame 5; `box_active` follows.
- Box inputs changed mid-frame → no change in the current frame; the new box appears in the next frame.
- Degenerate box top=50, down=40 or right=1280 → no pixels altered and `box_active`=0.
- With `BOX_CROSSHAIR_EN`, same box as above → (230,120) and (215,120) are `BOX_COLOR`; (215,110) passes through.

Source files
------------

// File: rtl/box_overlay_if.sv
// Pixel-stream and box-result bundle for box_overlay.
// master: video source / detector side (drives per_* and in_*, receives post_*).
// slave : overlay block (receives per_* and in_*, drives post_* and box_active).
interface box_overlay_if;
  localparam int unsigned PIX_W = 24;
  localparam int unsigned COORD_W = 12;

  logic               per_frame_vsync;
  logic               per_frame_href;
  logic               per_frame_clken;
  logic [PIX_W-1:0]   per_img_Bit;

  logic               in_en;
  logic [COORD_W-1:0] in_top;
  logic [COORD_W-1:0] in_down;
  logic [COORD_W-1:0] in_left;
  logic [COORD_W-1:0] in_right;

  logic               post_frame_vsync;
  logic               post_frame_href;
  logic               post_frame_clken;
  logic [PIX_W-1:0]   post_img_Bit;
  logic               box_active;

  modport master (
    output per_frame_vsync, per_frame_href, per_frame_clken, per_img_Bit,
    output in_en, in_top, in_down, in_left, in_right,
    input  post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit,
    input  box_active
  );

  modport slave (
    input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_Bit,
    input  in_en, in_top, in_down, in_left, in_right,
    output post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit,
    output box_active
  );
endinterface

// File: rtl/box_overlay.sv
// box_overlay: paints a rectangular border (BOX_COLOR) onto a pixel stream.
// The detector box is latched once per frame (one cycle after the vsync rise)
// and a hold FSM keeps the last box visible for HOLD_FRAMES frames after the
// detector drops in_en. All outputs are registered with 1 clock latency.
// Ports:
//   clk   : pixel clock
//   rst_n : asynchronous active-low reset
//   bus   : box_overlay_if.slave (per_* in, in_* box, post_* out, box_active)
// Optional feature: define BOX_CROSSHAIR_EN to also paint the centre
// crosshair lines (x==cx or y==cy) inside the box.
module box_overlay #(
  parameter logic [11:0] IMG_HDISP   = 12'd1280,
  parameter logic [11:0] IMG_VDISP   = 12'd720,
  parameter logic [3:0]  THICK       = 4'd2,
  parameter logic [3:0]  HOLD_FRAMES = 4'd3,
  parameter logic [23:0] BOX_COLOR   = 24'hFF0000
) (
  input  logic         clk,
  input  logic         rst_n,
  box_overlay_if.slave bus
);
  localparam int unsigned COORD_W = 12;
  localparam int unsigned EXT_W   = COORD_W + 1;
  localparam int unsigned PIX_W   = 24;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  typedef struct packed {
    logic [COORD_W-1:0] top;
    logic [COORD_W-1:0] down;
    logic [COORD_W-1:0] left;
    logic [COORD_W-1:0] right;
  } box_t;

  logic               vsync_r_q,    vsync_r_d;
  logic               cap_flag_q,   cap_flag_d;
  logic [COORD_W-1:0] x_q,          x_d;
  logic [COORD_W-1:0] y_q,          y_d;
  state_e             state_q,      state_d;
  logic [CNT_W-1:0]   hold_cnt_q,   hold_cnt_d;
  box_t               box_q,        box_d;
  logic               box_active_q, box_active_d;
  logic               post_vsync_q, post_vsync_d;
  logic               post_href_q,  post_href_d;
  logic               post_clken_q, post_clken_d;
  logic [PIX_W-1:0]   post_pix_q,   post_pix_d;
`ifdef BOX_CROSSHAIR_EN
  logic [COORD_W-1:0] cx_q,         cx_d;
  logic [COORD_W-1:0] cy_q,         cy_d;
`endif

  logic               vsync_pos_c;
  box_t               box_in_c;
  logic               in_box_c;
  logic               edge_c;
  logic               mark_c;
  logic [EXT_W-1:0]   x_e, y_e, th_e;
  logic [EXT_W-1:0]   top_e, down_e, left_e, right_e;

  // Next-state logic for counters, hold FSM, box latch and output pixel.
  always_comb begin
    vsync_r_d    = bus.per_frame_vsync;
    cap_flag_d   = 1'b0;
    x_d          = x_q;
    y_d          = y_q;
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    box_d        = box_q;
    box_active_d = box_active_q;
`ifdef BOX_CROSSHAIR_EN
    cx_d         = cx_q;
    cy_d         = cy_q;
`endif

    box_in_c.top   = bus.in_top;
    box_in_c.down  = bus.in_down;
    box_in_c.left  = bus.in_left;
    box_in_c.right = bus.in_right;

    vsync_pos_c = bus.per_frame_vsync & ~vsync_r_q;
    // Detector updates on the vsync rise, so sample its result one cycle later.
    cap_flag_d  = vsync_pos_c;

    // Raster position of the pixel presented this cycle.
    if (vsync_pos_c) begin
      x_d = '0;
      y_d = '0;
    end else if (bus.per_frame_clken) begin
      if (x_q == IMG_HDISP - 12'd1) begin
        x_d = '0;
        y_d = y_q + 12'd1;
      end else begin
        x_d = x_q + 12'd1;
      end
    end

    // Hold FSM steps once per frame.
    if (cap_flag_q) begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.in_en) begin
            box_d      = box_in_c;
            hold_cnt_d = '0;
            state_d    = ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (bus.in_en) begin
            box_d = box_in_c;
          end else if (HOLD_FRAMES == 4'd0) begin
            state_d = ST_IDLE;
          end else begin
            hold_cnt_d = 4'd1;
            state_d    = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.in_en) begin
            box_d      = box_in_c;
            hold_cnt_d = '0;
            state_d    = ST_SHOW;
          end else if (hold_cnt_q == HOLD_FRAMES) begin
            hold_cnt_d = '0;
            state_d    = ST_IDLE;
          end else begin
            hold_cnt_d = hold_cnt_q + 4'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      // Non-drawable boxes are latched but never painted.
      box_active_d = (state_d != ST_IDLE) &&
                     (box_d.top <= box_d.down) &&
                     (box_d.left <= box_d.right) &&
                     (box_d.right < IMG_HDISP) &&
                     (box_d.down < IMG_VDISP);
`ifdef BOX_CROSSHAIR_EN
      cx_d = {1'b0, box_d.left[COORD_W-1:1]} + {1'b0, box_d.right[COORD_W-1:1]};
      cy_d = {1'b0, box_d.top[COORD_W-1:1]}  + {1'b0, box_d.down[COORD_W-1:1]};
`endif
    end

    // Border test in 13 bits so +THICK never wraps.
    x_e     = {1'b0, x_q};
    y_e     = {1'b0, y_q};
    th_e    = EXT_W'(THICK);
    top_e   = {1'b0, box_q.top};
    down_e  = {1'b0, box_q.down};
    left_e  = {1'b0, box_q.left};
    right_e = {1'b0, box_q.right};

    in_box_c = (x_e >= left_e) && (x_e <= right_e) &&
               (y_e >= top_e)  && (y_e <= down_e);
    edge_c   = (x_e < left_e + th_e) || (x_e + th_e > right_e) ||
               (y_e < top_e + th_e)  || (y_e + th_e > down_e);
`ifdef BOX_CROSSHAIR_EN
    mark_c   = edge_c || (x_q == cx_q) || (y_q == cy_q);
`else
    mark_c   = edge_c;
`endif

    post_vsync_d = bus.per_frame_vsync;
    post_href_d  = bus.per_frame_href;
    post_clken_d = bus.per_frame_clken;
    post_pix_d   = (bus.per_frame_clken && box_active_q && in_box_c && mark_c) ?
                   BOX_COLOR : bus.per_img_Bit;
  end

  // All state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_r_q    <= 1'b0;
      cap_flag_q   <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      state_q      <= ST_IDLE;
      hold_cnt_q   <= '0;
      box_q        <= '0;
      box_active_q <= 1'b0;
      post_vsync_q <= 1'b0;
      post_href_q  <= 1'b0;
      post_clken_q <= 1'b0;
      post_pix_q   <= '0;
`ifdef BOX_CROSSHAIR_EN
      cx_q         <= '0;
      cy_q         <= '0;
`endif
    end else begin
      vsync_r_q    <= vsync_r_d;
      cap_flag_q   <= cap_flag_d;
      x_q          <= x_d;
      y_q          <= y_d;
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      box_q        <= box_d;
      box_active_q <= box_active_d;
      post_vsync_q <= post_vsync_d;
      post_href_q  <= post_href_d;
      post_clken_q <= post_clken_d;
      post_pix_q   <= post_pix_d;
`ifdef BOX_CROSSHAIR_EN
      cx_q         <= cx_d;
      cy_q         <= cy_d;
`endif
    end
  end

  assign bus.post_frame_vsync = post_vsync_q;
  assign bus.post_frame_href  = post_href_q;
  assign bus.post_frame_clken = post_clken_q;
  assign bus.post_img_Bit     = post_pix_q;
  assign bus.box_active       = box_active_q;

endmodule

// File: tb/tb_box_overlay.sv
// Self-checking bench for box_overlay: directed frames plus random boxes,
// every output cycle compared against a frame-level reference model.
module tb_box_overlay;
  localparam int HD         = 264;
  localparam int VD         = 150;
  localparam int TH         = 2;
  localparam int HF         = 3;
  localparam int SPEC_LINES = 142;
  localparam logic [23:0] COLOR = 24'hFF0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: frame-level view of what is drawn.
  bit m_show;
  int m_frames_left;
  int m_t, m_d, m_l, m_r;
  bit m_active;

  logic [23:0] obuf [HD*SPEC_LINES];
  logic [23:0] ibuf [HD*SPEC_LINES];

  always #5 clk = ~clk;

  box_overlay_if bus();

  box_overlay #(
    .IMG_HDISP   (12'(HD)),
    .IMG_VDISP   (12'(VD)),
    .THICK       (4'(TH)),
    .HOLD_FRAMES (4'(HF)),
    .BOX_COLOR   (COLOR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit border(input int x, input int y);
    if (!m_active) return 1'b0;
    if (x < m_l || x > m_r || y < m_t || y > m_d) return 1'b0;
    if (x - m_l < TH || m_r - x < TH || y - m_t < TH || m_d - y < TH) return 1'b1;
`ifdef BOX_CROSSHAIR_EN
    if (x == (m_l / 2 + m_r / 2) || y == (m_t / 2 + m_d / 2)) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic set_box(input logic en, input int t, input int d, input int l, input int r);
    bus.in_en    = en;
    bus.in_top   = 12'(t);
    bus.in_down  = 12'(d);
    bus.in_left  = 12'(l);
    bus.in_right = 12'(r);
  endtask

  // Model update at the frame's capture point.
  task automatic model_frame_start();
    if (bus.in_en) begin
      m_show        = 1'b1;
      m_frames_left = HF;
      m_t = int'(bus.in_top);
      m_d = int'(bus.in_down);
      m_l = int'(bus.in_left);
      m_r = int'(bus.in_right);
    end else if (m_show) begin
      if (m_frames_left == 0) m_show = 1'b0;
      else m_frames_left--;
    end
    m_active = m_show && (m_t <= m_d) && (m_l <= m_r) && (m_r < HD) && (m_d < VD);
  endtask

  task automatic cycle(input logic vs, input logic hr, input logic ck,
                       input int x, input int y, input bit chk_act);
    logic [23:0] pix;
    logic [23:0] exp_pix;
    pix = 24'($urandom) & 24'h7FFFFF;
    bus.per_frame_vsync = vs;
    bus.per_frame_href  = hr;
    bus.per_frame_clken = ck;
    bus.per_img_Bit     = pix;
    exp_pix = (ck && border(x, y)) ? COLOR : pix;
    @(posedge clk);
    #1;
    check("post_vsync", 32'(bus.post_frame_vsync), 32'(vs));
    check("post_href",  32'(bus.post_frame_href),  32'(hr));
    check("post_clken", 32'(bus.post_frame_clken), 32'(ck));
    check("post_pix",   32'(bus.post_img_Bit),     32'(exp_pix));
    if (chk_act) check("box_active", 32'(bus.box_active), 32'(m_active));
    if (ck && y < SPEC_LINES) begin
      obuf[y*HD + x] = bus.post_img_Bit;
      ibuf[y*HD + x] = pix;
    end
  endtask

  task automatic run_frame(input int nlines, input int chg_line, input logic nen,
                           input int nt, input int nd, input int nl, input int nr);
    cycle(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    model_frame_start();
    cycle(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
    for (int y = 0; y < nlines; y++) begin
      if (y == chg_line) set_box(nen, nt, nd, nl, nr);
      for (int x = 0; x < HD; x++) cycle(1'b1, 1'b1, 1'b1, x, y, 1'b1);
      cycle(1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
    end
  endtask

  task automatic spot(input string tag, input int x, input int y, input bit colored);
    int k;
    k = y*HD + x;
    check(tag, 32'(obuf[k]), colored ? 32'(COLOR) : 32'(ibuf[k]));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_vsync"}, 32'(bus.post_frame_vsync), 32'd0);
    check({tag, "_href"},  32'(bus.post_frame_href),  32'd0);
    check({tag, "_clken"}, 32'(bus.post_frame_clken), 32'd0);
    check({tag, "_pix"},   32'(bus.post_img_Bit),     32'd0);
    check({tag, "_act"},   32'(bus.box_active),       32'd0);
  endtask

  initial begin
    logic exp_hold [4];
    int t, d, l, r;
    logic en;

    set_box(1'b0, 0, 0, 0, 0);
    bus.per_frame_vsync = 1'b0;
    bus.per_frame_href  = 1'b0;
    bus.per_frame_clken = 1'b0;
    bus.per_img_Bit     = '0;
    m_show = 1'b0; m_frames_left = 0; m_active = 1'b0;
    m_t = 0; m_d = 0; m_l = 0; m_r = 0;

    // Reset values
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("reset");
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset_hold");
    @(negedge clk) rst_n = 1'b1;

    // Detector idle: pure pass-through
    run_frame(6, -1, 1'b0, 0, 0, 0, 0);
    check("idle_active", 32'(bus.box_active), 32'd0);

    // Reference box with spot checks
    set_box(1'b1, 100, 140, 200, 260);
    run_frame(SPEC_LINES, -1, 1'b0, 0, 0, 0, 0);
    check("spec_active", 32'(bus.box_active), 32'd1);
    spot("pt_200_100", 200, 100, 1'b1);
    spot("pt_201_101", 201, 101, 1'b1);
    spot("pt_260_140", 260, 140, 1'b1);
    spot("pt_230_139", 230, 139, 1'b1);
    spot("pt_202_102", 202, 102, 1'b0);
    spot("pt_199_100", 199, 100, 1'b0);
`ifdef BOX_CROSSHAIR_EN
    spot("pt_230_120", 230, 120, 1'b1);
    spot("pt_215_120", 215, 120, 1'b1);
    spot("pt_215_110", 215, 110, 1'b0);
`else
    spot("pt_230_120", 230, 120, 1'b0);
    spot("pt_215_120", 215, 120, 1'b0);
`endif

    // Hold: drawn three frames after in_en drops, gone on the fourth
    set_box(1'b1, 0, 5, 10, 40);
    run_frame(6, -1, 1'b0, 0, 0, 0, 0);
    check("hold_f1_active", 32'(bus.box_active), 32'd1);
    set_box(1'b0, 0, 5, 10, 40);
    exp_hold[0] = 1'b1; exp_hold[1] = 1'b1; exp_hold[2] = 1'b1; exp_hold[3] = 1'b0;
    for (int f = 0; f < 4; f++) begin
      run_frame(6, -1, 1'b0, 0, 0, 0, 0);
      check("hold_active", 32'(bus.box_active), 32'(exp_hold[f]));
    end

    // Box changed mid-frame: only takes effect next frame
    set_box(1'b1, 0, 3, 5, 30);
    run_frame(6, 2, 1'b1, 2, 5, 50, 80);
    run_frame(6, -1, 1'b0, 0, 0, 0, 0);
    check("midchg_left", 32'(m_l), 32'd50);

    // Degenerate boxes are never drawn; right edge at HDISP-1 is
    set_box(1'b1, 50, 40, 10, 40);
    run_frame(6, -1, 1'b0, 0, 0, 0, 0);
    check("degen_td_active", 32'(bus.box_active), 32'd0);
    set_box(1'b1, 0, 5, 10, HD);
    run_frame(6, -1, 1'b0, 0, 0, 0, 0);
    check("degen_r_active", 32'(bus.box_active), 32'd0);
    set_box(1'b1, 0, 5, HD-8, HD-1);
    run_frame(6, -1, 1'b0, 0, 0, 0, 0);
    check("edge_r_active", 32'(bus.box_active), 32'd1);

    // Random boxes and detector dropouts
    for (int i = 0; i < 5; i++) begin
      en = ($urandom_range(0, 3) != 0);
      t  = int'($urandom_range(0, 7));
      d  = int'($urandom_range(0, 7));
      l  = int'($urandom_range(0, HD + 1));
      r  = int'($urandom_range(0, HD + 1));
      set_box(en, t, d, l, r);
      run_frame(6, -1, 1'b0, 0, 0, 0, 0);
    end

    // Asynchronous reset mid-frame
    set_box(1'b1, 0, 5, 20, 60);
    run_frame(3, -1, 1'b0, 0, 0, 0, 0);
    bus.per_frame_href  = 1'b1;
    bus.per_frame_clken = 1'b1;
    rst_n = 1'b0;
    #1 check_outputs_zero("midreset");
    m_show = 1'b0; m_frames_left = 0; m_active = 1'b0;
    @(posedge clk);
    #1 check_outputs_zero("midreset_hold");
    bus.per_frame_vsync = 1'b0;
    bus.per_frame_href  = 1'b0;
    bus.per_frame_clken = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    set_box(1'b0, 0, 5, 20, 60);
    run_frame(6, -1, 1'b0, 0, 0, 0, 0);
    check("postreset_idle", 32'(bus.box_active), 32'd0);
    set_box(1'b1, 0, 5, 20, 60);
    run_frame(6, -1, 1'b0, 0, 0, 0, 0);
    check("postreset_draw", 32'(bus.box_active), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
